ex_seg: RTL and testbench

Execute (EX) stage of the five-stage R/I/J-type MIPS-subset pipeline. It takes the ID/EX values (instruction, next PC, operands A/B, sign-extended immediate) and computes the ALU result, the effective address, or the branch/jump target. It also evaluates the branch condition. All results are registered into the EX/MEM pipeline register for the MEM stage.

---
 rtl/rij_pkg.sv | 65 ++++++
 rtl/ex_alu.sv | 34 +++
 rtl/ex_seg.sv | 159 +++++++++++++++
 tb/tb_ex_seg.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rij_pkg.sv
// Shared definitions for the R/I/J-type MIPS-subset pipeline stages:
// the data word type, opcode and funct encodings, and the EX-stage
// ALU and operand-B selects.
package rij_pkg;

  typedef logic [31:0] word_t;

  // Primary opcodes, IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes, IR[5:0]
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // ALU operation select; ALU_ZERO is what unsupported encodings decode to
  typedef enum logic [3:0] {
    ALU_ZERO,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_LUI,
    ALU_PASSA
  } alu_op_e;

  // Second ALU operand source
  typedef enum logic [1:0] {
    BSEL_B,
    BSEL_IMM,
    BSEL_ZIMM
  } bsel_e;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU for the EX stage. All arithmetic wraps modulo 2^32;
// there is no overflow detection.
module ex_alu
  import rij_pkg::*;
(
  input  alu_op_e     op,
  input  word_t       a,
  input  word_t       b,
  input  logic [4:0]  shamt,
  output word_t       result
);

  // Select the result of the requested operation; anything else yields 0
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_NOR:   result = ~(a | b);
      ALU_SLT:   result = {31'b0, ($signed(a) < $signed(b))};
      ALU_SLTU:  result = {31'b0, (a < b)};
      ALU_SLL:   result = b << shamt;
      ALU_SRL:   result = b >> shamt;
      ALU_SRA:   result = word_t'($signed(b) >>> shamt);
      ALU_LUI:   result = {b[15:0], 16'b0};
      ALU_PASSA: result = a;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/ex_seg.sv
// EX pipeline stage: decodes the ID/EX instruction, runs the ALU or the
// branch/jump target logic, and registers the outcome into EX/MEM.
// There is no valid/ready handshake and no stall: every rising edge of
// clk captures a new instruction, and rst (active-low, asynchronous)
// clears EX/MEM to a NOP immediately.
module ex_seg
  import rij_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  word_t IRi,
  input  word_t NPCi,
  input  word_t Ai,
  input  word_t Bi,
  input  word_t Immi,
  output logic  cond,
  output word_t ALUo,
  output word_t Bo,
  output word_t IRo
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] shamt;
  word_t      zimm;

  assign op    = IRi[31:26];
  assign funct = IRi[5:0];
  assign shamt = IRi[10:6];
  assign zimm  = {16'b0, IRi[15:0]};

  alu_op_e alu_sel;
  bsel_e   bsel;
  word_t   alu_b;
  word_t   alu_res;
  word_t   br_tgt;
  word_t   j_tgt;
  logic    use_tgt;
  logic    tgt_is_j;
  logic    nxt_cond;
  word_t   nxt_alu;

  // Branch target is always computed, taken or not
  assign br_tgt = NPCi + {Immi[29:0], 2'b00};
  assign j_tgt  = {NPCi[31:28], IRi[25:0], 2'b00};

  // Decode opcode/funct into ALU select, operand-B source and cond
  always_comb begin
    alu_sel  = ALU_ZERO;
    bsel     = BSEL_B;
    use_tgt  = 1'b0;
    tgt_is_j = 1'b0;
    nxt_cond = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: alu_sel = ALU_ADD;
          FN_SUB, FN_SUBU: alu_sel = ALU_SUB;
          FN_AND:          alu_sel = ALU_AND;
          FN_OR:           alu_sel = ALU_OR;
          FN_XOR:          alu_sel = ALU_XOR;
          FN_NOR:          alu_sel = ALU_NOR;
          FN_SLT:          alu_sel = ALU_SLT;
          FN_SLTU:         alu_sel = ALU_SLTU;
          FN_SLL:          alu_sel = ALU_SLL;
          FN_SRL:          alu_sel = ALU_SRL;
          FN_SRA:          alu_sel = ALU_SRA;
          FN_JR: begin
            alu_sel  = ALU_PASSA;
            nxt_cond = 1'b1;
          end
          default:         alu_sel = ALU_ZERO;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
        alu_sel = ALU_ADD;
        bsel    = BSEL_IMM;
      end
      OP_SLTI: begin
        alu_sel = ALU_SLT;
        bsel    = BSEL_IMM;
      end
      OP_SLTIU: begin
        alu_sel = ALU_SLTU;
        bsel    = BSEL_IMM;
      end
      OP_ANDI: begin
        alu_sel = ALU_AND;
        bsel    = BSEL_ZIMM;
      end
      OP_ORI: begin
        alu_sel = ALU_OR;
        bsel    = BSEL_ZIMM;
      end
      OP_XORI: begin
        alu_sel = ALU_XOR;
        bsel    = BSEL_ZIMM;
      end
      OP_LUI: begin
        alu_sel = ALU_LUI;
        bsel    = BSEL_ZIMM;
      end
      OP_BEQ: begin
        use_tgt  = 1'b1;
        nxt_cond = (Ai == Bi);
      end
      OP_BNE: begin
        use_tgt  = 1'b1;
        nxt_cond = (Ai != Bi);
      end
      OP_J: begin
        use_tgt  = 1'b1;
        tgt_is_j = 1'b1;
        nxt_cond = 1'b1;
      end
      default: alu_sel = ALU_ZERO;
    endcase
  end

  // Operand-B mux: register, sign-extended or zero-extended immediate
  always_comb begin
    alu_b = Bi;
    case (bsel)
      BSEL_IMM:  alu_b = Immi;
      BSEL_ZIMM: alu_b = zimm;
      default:   alu_b = Bi;
    endcase
  end

  ex_alu u_alu (
    .op     (alu_sel),
    .a      (Ai),
    .b      (alu_b),
    .shamt  (shamt),
    .result (alu_res)
  );

  // Control transfers replace the ALU result with their target
  always_comb begin
    nxt_alu = alu_res;
    if (use_tgt) nxt_alu = tgt_is_j ? j_tgt : br_tgt;
  end

  // EX/MEM pipeline register; reset leaves a NOP in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cond <= 1'b0;
      ALUo <= '0;
      Bo   <= '0;
      IRo  <= '0;
    end else begin
      cond <= nxt_cond;
      ALUo <= nxt_alu;
      Bo   <= Bi;
      IRo  <= IRi;
    end
  end

endmodule

// File: tb/tb_ex_seg.sv
// Self-checking bench for ex_seg: directed cases, reset behaviour and a
// randomized run of R-type operations against a small reference model.
module tb_ex_seg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] IRi = '0;
  logic [31:0] NPCi = '0;
  logic [31:0] Ai = '0;
  logic [31:0] Bi = '0;
  logic [31:0] Immi = '0;
  logic        cond;
  logic [31:0] ALUo;
  logic [31:0] Bo;
  logic [31:0] IRo;

  int checks = 0;
  int errors = 0;

  // Expected EX/MEM contents packed as {cond, ALUo, Bo, IRo}
  logic [96:0] exp_q[$];

  ex_seg dut (
    .clk  (clk),
    .rst  (rst),
    .IRi  (IRi),
    .NPCi (NPCi),
    .Ai   (Ai),
    .Bi   (Bi),
    .Immi (Immi),
    .cond (cond),
    .ALUo (ALUo),
    .Bo   (Bo),
    .IRo  (IRo)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ir, input logic [31:0] npc,
                       input logic [31:0] a, input logic [31:0] b);
    IRi  = ir;
    NPCi = npc;
    Ai   = a;
    Bi   = b;
    Immi = {{16{ir[15]}}, ir[15:0]};
  endtask

  task automatic compare(input string tag);
    logic [96:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got empty scoreboard expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".cond"}, {31'b0, cond}, {31'b0, e[96]});
      check({tag, ".alu"},  ALUo, e[95:64]);
      check({tag, ".b"},    Bo,   e[63:32]);
      check({tag, ".ir"},   IRo,  e[31:0]);
    end
  endtask

  // Drive one instruction, record its expected outcome, check after one edge
  task automatic issue(input string tag, input logic [31:0] ir, input logic [31:0] npc,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_alu, input logic exp_cond);
    drive(ir, npc, a, b);
    exp_q.push_back({exp_cond, exp_alu, b, ir});
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  // Reference model for the randomized R-type ops
  function automatic logic [31:0] model_r(input logic [5:0] fn, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] r;
    r = 32'h0;
    case (fn)
      6'h21: r = a + b;
      6'h23: r = a + (~b + 32'd1);
      6'h26: r = (a | b) & ~(a & b);
      6'h27: r = ~a & ~b;
      6'h2A: r = (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, (a < b)};
      6'h2B: r = (a < b) ? 32'd1 : 32'd0;
      6'h02: begin
        r = b;
        for (int i = 0; i < 32; i++) if (i < int'(sh)) r = {1'b0, r[31:1]};
      end
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  initial begin
    logic [5:0]  fns [8];
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    fns = '{6'h21, 6'h23, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h02, 6'h21};

    // Asynchronous reset before any clock edge, with random inputs
    drive($urandom, $urandom, $urandom, $urandom);
    #1 rst = 1'b0;
    #1;
    check("rst_async.cond", {31'b0, cond}, 32'h0);
    check("rst_async.alu",  ALUo, 32'h0);
    check("rst_async.b",    Bo,   32'h0);
    check("rst_async.ir",   IRo,  32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold.alu", ALUo, 32'h0);
    check("rst_hold.ir",  IRo,  32'h0);
    @(negedge clk);
    rst = 1'b1;

    // add, sub
    issue("add",  32'h00221820, 32'h4, 32'd5, 32'd7, 32'd12, 1'b0);
    issue("sub",  32'h00221822, 32'h8, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0);

    // Reset mid-stream discards the in-flight result without an edge
    drive(32'h00221820, 32'h0, 32'd1, 32'd2);
    #2 rst = 1'b0;
    #1;
    check("rst_mid.cond", {31'b0, cond}, 32'h0);
    check("rst_mid.alu",  ALUo, 32'h0);
    check("rst_mid.b",    Bo,   32'h0);
    check("rst_mid.ir",   IRo,  32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Compare and shift
    issue("slt",  32'h0022182A, 32'h0, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);
    issue("sltu", 32'h0022182B, 32'h0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
    issue("sra",  32'h00021903, 32'h0, 32'h0, 32'h80000000, 32'hF8000000, 1'b0);
    issue("sll",  32'h00021900, 32'h0, 32'h0, 32'h80000001, 32'h00000010, 1'b0);
    issue("nop",  32'h00000000, 32'h0, 32'h5, 32'h0, 32'h0, 1'b0);

    // Load/store and immediate logic
    issue("lw",   32'h8C22FFFC, 32'h0, 32'h100, 32'h9, 32'hFC, 1'b0);
    issue("sw",   32'hAC220010, 32'h0, 32'h100, 32'hABCD, 32'h110, 1'b0);
    issue("ori",  32'h34028000, 32'h0, 32'h0, 32'h0, 32'h00008000, 1'b0);
    issue("andi", 32'h3022F0F0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0000F0F0, 1'b0);
    issue("slti", 32'h2822FFFF, 32'h0, 32'hFFFFFFFE, 32'h0, 32'd1, 1'b0);
    issue("sltiu",32'h2C22FFFF, 32'h0, 32'h00000005, 32'h0, 32'd1, 1'b0);
    issue("lui",  32'h3C021234, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h12340000, 1'b0);
    issue("addi", 32'h2022FFFF, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0);

    // Branches: target computed whether taken or not
    issue("beq_t",  32'h10220004, 32'h40, 32'd3, 32'd3, 32'h50, 1'b1);
    issue("beq_nt", 32'h10220004, 32'h40, 32'd3, 32'd4, 32'h50, 1'b0);
    issue("bne_t",  32'h14220004, 32'h40, 32'd3, 32'd4, 32'h50, 1'b1);
    issue("beq_bk", 32'h1022FFFF, 32'h40, 32'd3, 32'd3, 32'h3C, 1'b1);

    // Jumps and unsupported encodings
    issue("j",     32'h08000010, 32'h40000004, 32'h0, 32'h0, 32'h40000040, 1'b1);
    issue("jr",    32'h00200008, 32'h0, 32'h1234, 32'h0, 32'h1234, 1'b1);
    issue("unsup", 32'hFC221234, 32'h0, 32'h55, 32'h66, 32'h0, 1'b0);
    issue("jal",   32'h0C000010, 32'h40000004, 32'h0, 32'h7, 32'h0, 1'b0);
    issue("badfn", 32'h0022183F, 32'h0, 32'h1, 32'h2, 32'h0, 1'b0);

    // Randomized R-type operations
    for (int n = 0; n < 24; n++) begin
      fn = fns[$urandom_range(0, 7)];
      a  = $urandom;
      b  = $urandom;
      sh = 5'($urandom_range(0, 31));
      issue("rand", {6'h00, 5'd1, 5'd2, 5'd3, sh, fn}, $urandom, a, b,
            model_r(fn, a, b, sh), 1'b0);
    end

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_drain: got %0d left expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
